// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types, default constants and lane-merge helper for the data-memory responder
package dm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dm_state_t;

    localparam int              DM_ADDR_W   = 14;
    localparam logic [13:0]     DM_END_ADDR = 14'h3fff;
    localparam logic [31:0]     DM_END_CODE = 32'hFFFF_FFFF;

    // Replace each byte lane of old_word whose mask bit is set with the matching lane of wdata.
    function automatic logic [31:0] dm_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  mask);
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                merged[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_byte_bank.sv
// rtl/dm_byte_bank.sv - one byte lane of the data SRAM: write-enabled array, registered read, fixed-address peek
module dm_byte_bank #(
    parameter int                ADDR_W    = 14,
    parameter int                DEPTH     = 16384,
    parameter logic [ADDR_W-1:0] PEEK_ADDR = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata,
    output logic [7:0]        o_peek
);

    // Never reset so that contents loaded through the hierarchy survive a reset.
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Array write; the read below sees the old byte on the same edge (read-before-write).
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read data register: cleared by reset, otherwise only a committing read changes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 8'h00;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
    // Current byte at the watched address, used to judge a partial-lane write to it.
    assign o_peek  = r_mem[PEEK_ADDR];

endmodule

// File: rtl/dm_wait_responder.sv
// rtl/dm_wait_responder.sv - CPU data-port SRAM responder with configurable wait states, stall and end flag
import dm_pkg::*;

module dm_wait_responder #(
    parameter int                ADDR_W      = DM_ADDR_W,
    parameter int                DEPTH       = 16384,
    parameter int                WAIT_CYCLES = 0,
    parameter int                CNT_W       = 4,
    parameter logic [ADDR_W-1:0] END_ADDR    = DM_END_ADDR,
    parameter logic [31:0]       END_CODE    = DM_END_CODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              read,
    input  logic [3:0]        write,
    input  logic [31:0]       DI,
    output logic [31:0]       DO,
    output logic              stall,
    output logic              sim_done
);

    localparam bit               L_ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] L_N         = CNT_W'(WAIT_CYCLES);

    dm_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_read;
    logic [3:0]        r_write;
    logic [31:0]       r_di;
    logic              r_done;

    logic              w_req;
    logic              w_accept;
    logic              w_commit;
    logic [ADDR_W-1:0] w_addr;
    logic              w_read;
    logic [3:0]        w_write;
    logic [31:0]       w_di;
    logic [31:0]       w_end_word;
    logic [31:0]       w_merged;

    assign w_req    = read | (|write);
    assign w_accept = (r_state == IDLE) && w_req;

    // Zero-wait accesses commit straight from the port; otherwise from the latched copy.
    assign w_commit = L_ZERO_WAIT ? w_accept : ((r_state == BUSY) && (r_cnt == L_N));
    assign w_addr   = L_ZERO_WAIT ? addr  : r_addr;
    assign w_read   = L_ZERO_WAIT ? read  : r_read;
    assign w_write  = L_ZERO_WAIT ? write : r_write;
    assign w_di     = L_ZERO_WAIT ? DI    : r_di;

    // Busy in the acceptance cycle and every BUSY cycle before the last, giving N stall cycles.
    assign stall    = !L_ZERO_WAIT && (w_accept || ((r_state == BUSY) && (r_cnt < L_N)));

    // Request latch and wait-state sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_write <= 4'h0;
            r_di    <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= addr;
                        r_read  <= read;
                        r_write <= write;
                        r_di    <= DI;
                        if (!L_ZERO_WAIT) begin
                            r_state <= BUSY;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == L_N) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_merged = dm_merge(w_end_word, w_di, w_write);

    // Sticky end flag: set when a committing write leaves END_CODE at END_ADDR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else if (w_commit && (|w_write) && (w_addr == END_ADDR) && (w_merged == END_CODE)) begin
            r_done <= 1'b1;
        end
    end

    assign sim_done = r_done;

    dm_byte_bank #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PEEK_ADDR(END_ADDR)) Memory_byte0 (
        .clk(clk), .rst(rst), .i_we(w_commit && w_write[0]), .i_re(w_commit && w_read),
        .i_addr(w_addr), .i_wdata(w_di[7:0]), .o_rdata(DO[7:0]), .o_peek(w_end_word[7:0])
    );
    dm_byte_bank #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PEEK_ADDR(END_ADDR)) Memory_byte1 (
        .clk(clk), .rst(rst), .i_we(w_commit && w_write[1]), .i_re(w_commit && w_read),
        .i_addr(w_addr), .i_wdata(w_di[15:8]), .o_rdata(DO[15:8]), .o_peek(w_end_word[15:8])
    );
    dm_byte_bank #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PEEK_ADDR(END_ADDR)) Memory_byte2 (
        .clk(clk), .rst(rst), .i_we(w_commit && w_write[2]), .i_re(w_commit && w_read),
        .i_addr(w_addr), .i_wdata(w_di[23:16]), .o_rdata(DO[23:16]), .o_peek(w_end_word[23:16])
    );
    dm_byte_bank #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PEEK_ADDR(END_ADDR)) Memory_byte3 (
        .clk(clk), .rst(rst), .i_we(w_commit && w_write[3]), .i_re(w_commit && w_read),
        .i_addr(w_addr), .i_wdata(w_di[31:24]), .o_rdata(DO[31:24]), .o_peek(w_end_word[31:24])
    );

endmodule

// File: tb/tb_dm_wait_responder.sv
// tb/tb_dm_wait_responder.sv - scoreboard bench for the responder with zero and three wait states
module tb_dm_wait_responder;

    localparam logic [13:0] END_A = 14'h3fff;
    localparam logic [31:0] END_C = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_s   [2];
    logic [13:0] addr_s  [2];
    logic        rd_s    [2];
    logic [3:0]  we_s    [2];
    logic [31:0] di_s    [2];
    logic [31:0] do_w    [2];
    logic        stall_w [2];
    logic        done_w  [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference: plain word arrays, a sticky flag per DUT and a queue of expected read data.
    bit [31:0] model    [2][16384];
    bit        done_exp [2];
    bit [31:0] q0 [$];
    bit [31:0] q1 [$];
    bit        pend     [2];
    bit [31:0] hold_exp [2];

    dm_wait_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst_s[0]), .addr(addr_s[0]), .read(rd_s[0]), .write(we_s[0]),
        .DI(di_s[0]), .DO(do_w[0]), .stall(stall_w[0]), .sim_done(done_w[0])
    );
    dm_wait_responder #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst_s[1]), .addr(addr_s[1]), .read(rd_s[1]), .write(we_s[1]),
        .DI(di_s[1]), .DO(do_w[1]), .stall(stall_w[1]), .sim_done(done_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic poke(input int d, input int a, input logic [31:0] v);
        model[d][a] = v;
        if (d == 0) begin
            dut0.Memory_byte0.r_mem[a] = v[7:0];
            dut0.Memory_byte1.r_mem[a] = v[15:8];
            dut0.Memory_byte2.r_mem[a] = v[23:16];
            dut0.Memory_byte3.r_mem[a] = v[31:24];
        end else begin
            dut3.Memory_byte0.r_mem[a] = v[7:0];
            dut3.Memory_byte1.r_mem[a] = v[15:8];
            dut3.Memory_byte2.r_mem[a] = v[23:16];
            dut3.Memory_byte3.r_mem[a] = v[31:24];
        end
    endtask

    function automatic logic [31:0] peek(input int d, input int a);
        if (d == 0)
            return {dut0.Memory_byte3.r_mem[a], dut0.Memory_byte2.r_mem[a],
                    dut0.Memory_byte1.r_mem[a], dut0.Memory_byte0.r_mem[a]};
        return {dut3.Memory_byte3.r_mem[a], dut3.Memory_byte2.r_mem[a],
                dut3.Memory_byte1.r_mem[a], dut3.Memory_byte0.r_mem[a]};
    endfunction

    // Issue one access (entered and left just after a rising edge), predict its effects.
    task automatic access(input int d, input logic [13:0] a, input logic r,
                          input logic [3:0] w, input logic [31:0] data);
        int        sc;
        bit        seen_low;
        bit [31:0] nw;
        addr_s[d] = a; rd_s[d] = r; we_s[d] = w; di_s[d] = data;
        if (r) begin
            if (d == 0) q0.push_back(model[d][a]);
            else        q1.push_back(model[d][a]);
        end
        sc = 0;
        seen_low = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall_w[d]) begin
                seen_low = 1'b1;
                break;
            end
            sc++;
            @(posedge clk); #1;
        end
        if (!seen_low) check("stall_timeout", 32'(sc), 32'(d == 0 ? 0 : 3));
        @(posedge clk); #1;
        nw = model[d][a];
        for (int k = 0; k < 4; k++) if (w[k]) nw[8*k +: 8] = data[8*k +: 8];
        model[d][a] = nw;
        if (w != 4'h0 && a == END_A && nw == END_C) done_exp[d] = 1'b1;
        check("stall_cycles", 32'(sc), 32'(d == 0 ? 0 : 3));
        check("sim_done", 32'(done_w[d]), 32'(done_exp[d]));
        rd_s[d] = 1'b0; we_s[d] = 4'h0;
    endtask

    task automatic random_run(input int d, input int n);
        logic [13:0] a;
        logic        r;
        logic [3:0]  w;
        for (int i = 0; i < n; i++) begin
            a = 14'($urandom_range(0, 63));
            r = 1'($urandom_range(0, 1));
            w = 4'($urandom_range(0, 15));
            if (r && $urandom_range(0, 1) == 0) w = 4'h0;
            if (!r && w == 4'h0) w = 4'hF;
            access(d, a, r, w, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Monitor: a read committing in this cycle must show its word on DO one edge later; otherwise DO holds.
    always @(negedge clk) begin
        bit [31:0] e;
        for (int d = 0; d < 2; d++) begin
            e = hold_exp[d];
            if (rst_s[d]) begin
                e = 32'h0;
            end else if (pend[d]) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0)
                    check("scoreboard_underflow", 32'h1, 32'h0);
                else
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
            end
            check(d == 0 ? "DO_w0" : "DO_w3", do_w[d], e);
            hold_exp[d] <= e;
            pend[d]     <= rd_s[d] && !stall_w[d] && !rst_s[d];
        end
    end

    initial begin
        int c0;
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; addr_s[d] = '0; rd_s[d] = 1'b0; we_s[d] = 4'h0; di_s[d] = 32'h0;
            done_exp[d] = 1'b0;
            for (int i = 0; i < 64; i++) poke(d, i, (i == 0) ? 32'h1234_5678 : $urandom);
            poke(d, int'(END_A), 32'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_DO", do_w[d], 32'h0);
            check("reset_stall", 32'(stall_w[d]), 32'h0);
            check("reset_sim_done", 32'(done_w[d]), 32'h0);
            rst_s[d] = 1'b0;
        end
        @(posedge clk); #1;

        // Zero wait states: preload survives, write/read, lanes with concurrent read, end detection.
        access(0, 14'h0000, 1'b1, 4'h0, 32'h0);
        access(0, 14'h0010, 1'b0, 4'hF, 32'hDEAD_BEEF);
        access(0, 14'h0010, 1'b1, 4'h0, 32'h0);
        access(0, 14'h0010, 1'b1, 4'b0101, 32'h1122_3344);
        access(0, 14'h0010, 1'b1, 4'h0, 32'h0);
        check("lane_merge_w0", peek(0, 16), 32'hDE22_BE44);
        access(0, END_A, 1'b0, 4'b0011, 32'h0000_FFFF);
        check("end_partial_low", 32'(done_w[0]), 32'h0);
        access(0, END_A, 1'b0, 4'b1100, 32'hFFFF_0000);
        check("end_merged_set", 32'(done_w[0]), 32'h1);
        access(0, END_A, 1'b0, 4'hF, 32'h0);
        check("end_sticky", 32'(done_w[0]), 32'h1);
        random_run(0, 60);

        // Three wait states: stall length, back-to-back timing, reset in the middle of an access.
        access(1, 14'h0010, 1'b0, 4'hF, 32'hDEAD_BEEF);
        c0 = cyc;
        access(1, 14'h0010, 1'b1, 4'h0, 32'h0);
        access(1, 14'h0010, 1'b1, 4'h0, 32'h0);
        check("back_to_back_cycles", 32'(cyc - c0), 32'd8);

        addr_s[1] = 14'h0020; rd_s[1] = 1'b0; we_s[1] = 4'hF; di_s[1] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("pre_reset_stall", 32'(stall_w[1]), 32'h1);
        rst_s[1] = 1'b1; we_s[1] = 4'h0;
        #1;
        check("midbusy_stall", 32'(stall_w[1]), 32'h0);
        check("midbusy_DO", do_w[1], 32'h0);
        @(posedge clk); #1;
        rst_s[1] = 1'b0;
        @(posedge clk); #1;
        check("midbusy_word", peek(1, 32), model[1][32]);
        access(1, 14'h0020, 1'b1, 4'h0, 32'h0);
        random_run(1, 30);

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) check("golden_word", peek(d, i), model[d][i]);
            check("golden_end", peek(d, int'(END_A)), model[d][int'(END_A)]);
        end
        check("queue0_drained", 32'(q0.size()), 32'h0);
        check("queue1_drained", 32'(q1.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_wait_responder.md
Name: dm_wait_responder

Overview:
- Memory-side responder for the CPU data port: a word-addressed, byte-lane-writable SRAM model with a configurable wait-state count and a stall handshake back to the CPU.
- Sits where the data SRAM sits today and drives CPU stall when WAIT_CYCLES > 0; with WAIT_CYCLES = 0 it matches the existing single-edge SRAM timing.
- Also provides a sticky end-of-simulation flag, raised when the end code is written to the end address.

Parameters:
- ADDR_W, 14, word-address width (addr = byte address [15:2]).
- DEPTH, 16384, words in the array (2**ADDR_W).
- WAIT_CYCLES, 0, stall cycles inserted per access; legal range 0..15.
- CNT_W, 4, wait counter width; must hold WAIT_CYCLES.
- END_ADDR, 14'h3fff, word address watched for end of simulation.
- END_CODE, 32'hFFFF_FFFF, value at END_ADDR that signals done.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  ADDR_W  word address of the request.
- read  in  1  read request.
- write  in  4  byte-lane write enables; bit k writes DI[8k+7:8k].
- DI  in  32  write data.
- DO  out  32  read data.
- stall  out  1  responder busy; CPU must hold addr, read, write and DI stable while this is high.
- sim_done  out  1  sticky end-of-simulation flag.

Behaviour:
- Request: req = read | (|write).
- States: IDLE, BUSY.
- Reset (asynchronous):
  - state = IDLE, wait counter = 0, DO = 0, stall = 0, sim_done = 0.
  - Array contents are not cleared (preload by hierarchical load must survive).
- Acceptance: a request is accepted in any IDLE cycle with req = 1, and its addr, read, write and DI are latched.
- WAIT_CYCLES = 0:
  - No state change; stall stays 0.
  - The access commits on the edge ending the acceptance cycle (one-edge latency, identical to the current SRAM).
- WAIT_CYCLES = N > 0:
  - stall is combinational: 1 in the acceptance cycle, and 1 while in BUSY with counter < N.
  - On acceptance: IDLE -> BUSY, counter = 1. Each BUSY cycle the counter increments.
  - In the BUSY cycle with counter == N, stall = 0. The access commits on the edge ending that cycle, and BUSY -> IDLE.
  - Result: stall is high for exactly N consecutive cycles per access.
- Commit rules:
  - Write: each lane k with write[k] = 1 gets latched DI lane k at latched addr. Unselected lanes are unchanged.
  - Read: DO <= array word at latched addr.
- Read and write asserted together: DO returns the pre-write word (read-before-write); the write still commits.
- DO holds its value until the next read commits. Writes never change DO.
- Back-to-back: a new request is accepted in the first IDLE cycle after a commit. Two accesses with N wait states take 2(N+1) cycles total.
- Latched request: inputs that change during BUSY are ignored (the latched request is used). The CPU contract is still to hold them stable.
- sim_done:
  - Set on the commit edge of any write to END_ADDR whose post-write word equals END_CODE. Partial-lane writes count if the merged word matches.
  - Stays 1 until reset. Later writes do not clear it.
- Reset mid-BUSY: the pending access is dropped (no array write, DO = 0), state = IDLE.
- Address wrap: addr is exactly ADDR_W bits, so there is no out-of-range case.

Decomposition:
- Package dm_pkg holds:
  - the state enum (IDLE, BUSY);
  - default constants DM_END_ADDR = 14'h3fff, DM_END_CODE = 32'hFFFF_FFFF, DM_ADDR_W = 14;
  - a lane-merge function (old word, DI, write mask) -> new word.
- Sub-module dm_byte_bank: one 8-bit x DEPTH array with write enable and synchronous read.
- Four instances, exposing hierarchical arrays Memory_byte0..3 so existing preload and golden-check flows keep working.

Test Plan:
- Reset then idle, WAIT_CYCLES = 0 -> DO = 0, stall = 0, sim_done = 0; array preloaded with 32'h1234_5678 at addr 0 survives reset.
- WAIT_CYCLES = 0:
  - write = 4'hF, addr = 14'h0010, DI = 32'hDEAD_BEEF;
  - next cycle read addr 14'h0010 -> DO = 32'hDEAD_BEEF one edge after the read cycle; stall never asserted.
- WAIT_CYCLES = 3:
  - read at addr 14'h0010 -> stall = 1 for exactly 3 cycles;
  - DO = 32'hDEAD_BEEF after the edge ending cycle 4;
  - second back-to-back read completes at cycle 8.
- Byte lanes: word = 32'hDEAD_BEEF, write = 4'b0101, DI = 32'h1122_3344 -> word = 32'hDE22_BE44. A concurrent read returns 32'hDEAD_BEEF.
- End detection:
  - write = 4'b0011, DI = 32'h0000_FFFF to END_ADDR -> sim_done stays 0;
  - then write = 4'b1100, DI = 32'hFFFF_0000 -> sim_done = 1 at that commit edge;
  - later write 32'h0 to END_ADDR -> sim_done stays 1.
- Reset mid-BUSY, WAIT_CYCLES = 3:
  - assert rst in the 2nd stall cycle of a write of 32'hCAFE_F00D to addr 14'h0020 -> stall = 0, DO = 0 immediately;
  - word at 14'h0020 is unchanged.
